// File: rtl/seletor_corrida.sv
`default_nettype none
// ============================================================================
// Module     : seletor_corrida
// Description: Ride origin/destination selector. Captures a one-hot origin
//              and destination from a 0..8 position index on confirm-button
//              rising edges, holds the request until accepted, tracks the
//              trip and clears on end of trip or cancel.
//              Optional feature macro: SELETOR_TIMEOUT_EN (PRONTO timeout).
// Revision   : 1.0 - initial release
// ============================================================================
module seletor_corrida #(
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sel,
  input  logic       confirma,
  input  logic       cancela,
  input  logic       aceite,
  input  logic       fim_viagem,
  output logic [8:0] inicio,
  output logic [8:0] fim,
  output logic       valido,
  output logic [1:0] estado,
  output logic       erro
);

  typedef enum logic [1:0] {
    INICIO  = 2'b00,
    DESTINO = 2'b01,
    PRONTO  = 2'b10,
    VIAGEM  = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] inicio_nxt;
  logic [8:0] fim_nxt;
  logic       erro_nxt;
  logic       conf_prev;
  logic       conf_edge;
  logic       sel_ok;
  logic [8:0] sel_onehot;
  logic       timeout;

  // One edge per press; conf_prev resets high so a button held through
  // reset release is not seen as a press.
  assign conf_edge  = confirma & ~conf_prev;
  assign sel_ok     = (sel <= 4'd8);
  assign sel_onehot = sel_ok ? (9'd1 << sel) : 9'd0;
  assign estado     = state;

`ifdef SELETOR_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS < 2) ? 1 : $clog2(TIMEOUT_CICLOS);

  logic [CW-1:0] cnt;

  // Counts PRONTO cycles; zero whenever the FSM is outside PRONTO, so it is
  // already clear on the first PRONTO cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != PRONTO) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT_CICLOS-th consecutive PRONTO cycle.
  assign timeout = (state == PRONTO) && (cnt == CW'(TIMEOUT_CICLOS - 1));
`else
  // No timeout hardware: PRONTO waits until accepted or cancelled.
  if (TIMEOUT_CICLOS >= 1) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_no_timeout_any
    assign timeout = 1'b0;
  end
`endif

  // Next-state and next-value logic for the request registers.
  always_comb begin
    state_nxt  = state;
    inicio_nxt = inicio;
    fim_nxt    = fim;
    erro_nxt   = 1'b0;
    case (state)
      INICIO: begin
        if (cancela) begin
          inicio_nxt = 9'd0;
          fim_nxt    = 9'd0;
        end else if (conf_edge) begin
          if (sel_ok) begin
            inicio_nxt = sel_onehot;
            state_nxt  = DESTINO;
          end else begin
            erro_nxt = 1'b1;
          end
        end
      end
      DESTINO: begin
        if (cancela) begin
          inicio_nxt = 9'd0;
          fim_nxt    = 9'd0;
          state_nxt  = INICIO;
        end else if (conf_edge) begin
          if (sel_ok && (sel_onehot != inicio)) begin
            fim_nxt   = sel_onehot;
            state_nxt = PRONTO;
          end else begin
            erro_nxt = 1'b1;
          end
        end
      end
      PRONTO: begin
        if (cancela) begin
          inicio_nxt = 9'd0;
          fim_nxt    = 9'd0;
          state_nxt  = INICIO;
        end else if (aceite) begin
          state_nxt = VIAGEM;
        end else if (timeout) begin
          inicio_nxt = 9'd0;
          fim_nxt    = 9'd0;
          erro_nxt   = 1'b1;
          state_nxt  = INICIO;
        end
      end
      VIAGEM: begin
        if (fim_viagem) begin
          inicio_nxt = 9'd0;
          fim_nxt    = 9'd0;
          state_nxt  = INICIO;
        end
      end
      default: begin
        state_nxt  = INICIO;
        inicio_nxt = 9'd0;
        fim_nxt    = 9'd0;
      end
    endcase
  end

  // State and output registers; valido is registered so it tracks PRONTO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INICIO;
      inicio    <= 9'd0;
      fim       <= 9'd0;
      valido    <= 1'b0;
      erro      <= 1'b0;
      conf_prev <= 1'b1;
    end else begin
      state     <= state_nxt;
      inicio    <= inicio_nxt;
      fim       <= fim_nxt;
      valido    <= (state_nxt == PRONTO);
      erro      <= erro_nxt;
      conf_prev <= confirma;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seletor_corrida.sv
`default_nettype none
// ============================================================================
// Module     : tb_seletor_corrida
// Description: Directed self-checking bench for seletor_corrida.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seletor_corrida;

  logic       clk;
  logic       rst_n;
  logic [3:0] sel;
  logic       confirma;
  logic       cancela;
  logic       aceite;
  logic       fim_viagem;
  logic [8:0] inicio;
  logic [8:0] fim;
  logic       valido;
  logic [1:0] estado;
  logic       erro;

  int n_checks = 0;
  int n_fail   = 0;

  // {estado, inicio, fim, valido, erro}
  logic [21:0] obs;
  assign obs = {estado, inicio, fim, valido, erro};

  seletor_corrida #(.TIMEOUT_CICLOS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .confirma   (confirma),
    .cancela    (cancela),
    .aceite     (aceite),
    .fim_viagem (fim_viagem),
    .inicio     (inicio),
    .fim        (fim),
    .valido     (valido),
    .estado     (estado),
    .erro       (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] s);
    sel = s;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    sel = 4'd0; confirma = 1'b0; cancela = 1'b0; aceite = 1'b0; fim_viagem = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    sel = 4'd0; confirma = 1'b0; cancela = 1'b0; aceite = 1'b0; fim_viagem = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL reset_async: got %b expected %b", obs, 22'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, 22'b0);
    end
  endtask

  task automatic test_main();
    do_reset();
    press(4'd2);
    n_checks++;
    if (obs !== {2'b01, 9'b000000100, 9'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL main_origin: got %b expected %b", obs, {2'b01, 9'b000000100, 9'b0, 2'b00});
    end
    press(4'd7);
    n_checks++;
    if (obs !== {2'b10, 9'b000000100, 9'b010000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL main_ready: got %b expected %b", obs, {2'b10, 9'b000000100, 9'b010000000, 2'b10});
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    press(4'd0);
    press(4'd8);
    n_checks++;
    if (obs !== {2'b10, 9'b000000001, 9'b100000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bound_0_8: got %b expected %b", obs, {2'b10, 9'b000000001, 9'b100000000, 2'b10});
    end
  endtask

  task automatic test_errors();
    do_reset();
    // Illegal origin, twice in a row: two separate one-cycle pulses.
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 4'd12 : 4'd9;
      confirma = 1'b1;
      tick();
      n_checks++;
      if (obs !== {2'b00, 9'b0, 9'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL err_origin_pulse%0d: got %b expected %b", k, obs, {2'b00, 18'b0, 2'b01});
      end
      confirma = 1'b0;
      tick();
      n_checks++;
      if (erro !== 1'b0) begin
        n_fail++; $display("FAIL err_origin_width%0d: got %b expected 0", k, erro);
      end
    end
    press(4'd2);
    // Destination equal to origin, then out of range.
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 4'd2 : 4'd9;
      confirma = 1'b1;
      tick();
      n_checks++;
      if (obs !== {2'b01, 9'b000000100, 9'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL err_dest_pulse%0d: got %b expected %b", k, obs, {2'b01, 9'b000000100, 9'b0, 2'b01});
      end
      confirma = 1'b0;
      tick();
      n_checks++;
      if (obs !== {2'b01, 9'b000000100, 9'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL err_dest_after%0d: got %b expected %b", k, obs, {2'b01, 9'b000000100, 9'b0, 2'b00});
      end
    end
  endtask

  task automatic test_trip();
    do_reset();
    aceite = 1'b1;
    tick();
    aceite = 1'b0;
    n_checks++;
    if (estado !== 2'b00) begin
      n_fail++; $display("FAIL trip_aceite_idle: got %b expected 00", estado);
    end
    press(4'd2);
    press(4'd7);
    aceite = 1'b1;
    tick();
    aceite = 1'b0;
    n_checks++;
    if (obs !== {2'b11, 9'b000000100, 9'b010000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL trip_accept: got %b expected %b", obs, {2'b11, 9'b000000100, 9'b010000000, 2'b00});
    end
    cancela = 1'b1;
    tick();
    cancela = 1'b0;
    press(4'd3);
    n_checks++;
    if (obs !== {2'b11, 9'b000000100, 9'b010000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL trip_ignore: got %b expected %b", obs, {2'b11, 9'b000000100, 9'b010000000, 2'b00});
    end
    fim_viagem = 1'b1;
    tick();
    fim_viagem = 1'b0;
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL trip_end: got %b expected %b", obs, 22'b0);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    press(4'd4);
    sel = 4'd5;
    cancela = 1'b1;
    confirma = 1'b1;
    tick();
    cancela = 1'b0;
    confirma = 1'b0;
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL cancel_vs_confirm: got %b expected %b", obs, 22'b0);
    end
    tick();
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL cancel_no_err: got %b expected %b", obs, 22'b0);
    end
    press(4'd1);
    press(4'd6);
    cancela = 1'b1;
    aceite = 1'b1;
    tick();
    cancela = 1'b0;
    aceite = 1'b0;
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL cancel_vs_aceite: got %b expected %b", obs, 22'b0);
    end
  endtask

  task automatic test_held_confirm();
    sel = 4'd3; cancela = 1'b0; aceite = 1'b0; fim_viagem = 1'b0;
    confirma = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL held_confirm: got %b expected %b", obs, 22'b0);
    end
    confirma = 1'b0;
    tick();
    press(4'd5);
    n_checks++;
    if (obs !== {2'b01, 9'b000100000, 9'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL held_then_press: got %b expected %b", obs, {2'b01, 9'b000100000, 9'b0, 2'b00});
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    press(4'd1);
    press(4'd6);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL midop_reset: got %b expected %b", obs, 22'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== 22'b0) begin
      n_fail++; $display("FAIL midop_release: got %b expected %b", obs, 22'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'd0);
    press(4'd8);
`ifdef SELETOR_TIMEOUT_EN
    // Two PRONTO cycles already elapsed; two more remain before timeout.
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (estado !== 2'b10) begin
        n_fail++; $display("FAIL timeout_wait%0d: got %b expected 10", k, estado);
      end
    end
    tick();
    n_checks++;
    if (obs !== {2'b00, 9'b0, 9'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_fire: got %b expected %b", obs, {2'b00, 18'b0, 2'b01});
    end
    tick();
    n_checks++;
    if (erro !== 1'b0) begin
      n_fail++; $display("FAIL timeout_width: got %b expected 0", erro);
    end
`else
    repeat (1000) tick();
    n_checks++;
    if (obs !== {2'b10, 9'b000000001, 9'b100000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL no_timeout: got %b expected %b", obs, {2'b10, 9'b000000001, 9'b100000000, 2'b10});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_main();
    test_boundaries();
    test_errors();
    test_trip();
    test_cancel();
    test_held_confirm();
    test_midop_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seletor_corrida.md
SELETOR_CORRIDA -- requirements
Module: seletor_corrida

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 255, cycles allowed in PRONTO before timeout (used only with the timeout feature compiled in).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sel  input  4  position index chosen by user; legal 0..8.
REQ-005 confirma  input  1  confirm button, synchronous level; block detects its rising edge.
REQ-006 cancela  input  1  cancel request, synchronous level, sampled every cycle.
REQ-007 aceite  input  1  downstream accept of the completed ride request.
REQ-008 fim_viagem  input  1  single-cycle pulse marking end of trip.
REQ-009 inicio  output  9  one-hot origin vector, feeds the position-combining stage.
REQ-010 fim  output  9  one-hot destination vector, feeds the position-combining stage.
REQ-011 valido  output  1  high while a complete request awaits acceptance.
REQ-012 estado  output  2  current FSM state encoding.
REQ-013 erro  output  1  single-cycle pulse on rejected input or timeout.

Function
REQ-014 FSM states SHALL be INICIO=00, DESTINO=01, PRONTO=10, VIAGEM=11.
REQ-015 Confirm edge SHALL be confirma=1 with registered previous value 0; one edge per press.
REQ-016 INICIO + edge, sel<=8: inicio <= 1<<sel, next DESTINO.
REQ-017 INICIO + edge, sel>8: erro pulse next cycle, inicio unchanged, stay INICIO.
REQ-018 DESTINO + edge, sel<=8 and 1<<sel != inicio: fim <= 1<<sel, next PRONTO.
REQ-019 DESTINO + edge, sel>8 or sel equal to origin: erro pulse, fim unchanged, stay DESTINO.
REQ-020 PRONTO: valido=1 (registered, asserted the cycle estado=10); inicio/fim held stable.
REQ-021 PRONTO + aceite=1: next VIAGEM, valido deasserts same edge; aceite ignored in all other states.
REQ-022 VIAGEM: inicio/fim held; confirma and cancela ignored; fim_viagem=1 clears inicio and fim to 0, next INICIO.
REQ-023 cancela=1 in INICIO, DESTINO or PRONTO: inicio=0, fim=0, valido=0, next INICIO, no erro.
REQ-024 cancela and confirm edge in same cycle: cancela wins; edge discarded.
REQ-025 cancela and aceite in same cycle in PRONTO: cancela wins.
REQ-026 inicio and fim SHALL always be all-zero or exactly one bit set; never equal when both nonzero.
REQ-027 erro SHALL be exactly one cycle wide per event; back-to-back bad edges give separate pulses.

Reset
REQ-028 rst_n=0 SHALL immediately force estado=INICIO, inicio=0, fim=0, valido=0, erro=0, timeout counter=0.
REQ-029 Registered previous-confirma SHALL reset to 1 so a button held through reset release creates no edge.
REQ-030 Reset asserted mid-operation (any state) SHALL discard the pending request with no erro pulse.

Configuration
REQ-031 Macro SELETOR_TIMEOUT_EN, when defined, SHALL compile in a counter cleared on entry to PRONTO and incremented each PRONTO cycle.
REQ-032 With SELETOR_TIMEOUT_EN: counter reaching TIMEOUT_CICLOS without aceite or cancela SHALL clear inicio/fim, pulse erro, go INICIO; aceite on that same cycle wins.
REQ-033 Without SELETOR_TIMEOUT_EN: no counter logic; PRONTO waits indefinitely.

Verification
REQ-034 Reset, sel=2 edge, sel=7 edge -> inicio=000000100, fim=010000000, estado=10, valido=1.
REQ-035 In DESTINO with origin 2: sel=2 edge -> erro one cycle, estado=01, fim=0; sel=9 edge -> same.
REQ-036 PRONTO, aceite=1 -> estado=11, valido=0; cancela/confirma ignored; fim_viagem pulse -> inicio=fim=0, estado=00.
REQ-037 DESTINO, cancela and confirma edge same cycle -> estado=00, inicio=fim=0, erro=0.
REQ-038 confirma held high across rst_n release -> no transition until released and pressed again.
REQ-039 SELETOR_TIMEOUT_EN, TIMEOUT_CICLOS=4, PRONTO with no aceite -> after 4 cycles erro pulse, estado=00; without macro -> stays PRONTO 1000 cycles.
